// File: rtl/mag_shift_add_mult.sv
// -----------------------------------------------------------------------------
// mag_shift_add_mult
//
// Sequential sign-magnitude multiplier. It takes two unsigned magnitudes and
// their sign bits, forms the unsigned product by shift-and-add (one multiplier
// bit per cycle, always MAG_WIDTH iterations), then applies the XOR of the signs
// to produce a two's-complement signed product. Valid/ready handshakes on both
// sides let one instance be time-multiplexed across FIR taps.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (high only in IDLE)
//   a_mag      in   [MAG_WIDTH-1:0] unsigned magnitude of A
//   a_sign     in   sign of A (1 = negative)
//   b_mag      in   [MAG_WIDTH-1:0] unsigned magnitude of B
//   b_sign     in   sign of B (1 = negative)
//   out_valid  out  product valid (held until out_ready)
//   out_ready  in   consumer accepts product
//   product    out  [2*MAG_WIDTH:0] signed two's-complement product
//   busy       out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module mag_shift_add_mult #(
  parameter int MAG_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAG_WIDTH-1:0]   a_mag,
  input  logic                   a_sign,
  input  logic [MAG_WIDTH-1:0]   b_mag,
  input  logic                   b_sign,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*MAG_WIDTH:0]   product,
  output logic                   busy
);

  localparam int PROD_WIDTH = 2 * MAG_WIDTH + 1;
  localparam int ACC_WIDTH  = 2 * MAG_WIDTH;
  // One extra bit so the counter can represent MAG_WIDTH-1 for any width.
  localparam int CNT_WIDTH  = $clog2(MAG_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(MAG_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [ACC_WIDTH-1:0]   r_mcand;   // multiplicand, shifts left each iteration
  logic [MAG_WIDTH-1:0]   r_mplier;  // multiplier, shifts right each iteration
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_neg;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_out_valid;
  logic [PROD_WIDTH-1:0]  r_product;

  logic [PROD_WIDTH-1:0]  w_prod_mag;

  // Magnitude widened by a zero MSB so negation is exact; negating zero gives
  // zero, so a zero magnitude never produces a negative-zero pattern.
  assign w_prod_mag = {1'b0, r_acc};

  // Derived only from registered state: no combinational path from in_valid
  // or out_ready reaches any output.
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign product   = r_product;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_product   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{MAG_WIDTH{1'b0}}, a_mag};
            r_mplier <= b_mag;
            r_acc    <= '0;
            r_neg    <= a_sign ^ b_sign;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end

        RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // Fixed iteration count keeps latency independent of the data.
          if (r_cnt == LAST_ITER) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          r_product   <= r_neg ? (~w_prod_mag + 1'b1) : w_prod_mag;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end

        DONE: begin
          // product keeps its value after the handoff.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_mag_shift_add_mult
//
// Self-checking bench for mag_shift_add_mult (MAG_WIDTH = 16). Expected
// products come from plain signed integer arithmetic on the operands; latency,
// busy duration, output hold behaviour and mid-operation reset are checked
// against fixed expectations.
// -----------------------------------------------------------------------------
module tb_mag_shift_add_mult;

  localparam int W  = 16;
  localparam int PW = 2 * W + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_mag;
  logic          a_sign;
  logic [W-1:0]  b_mag;
  logic          b_sign;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int errors = 0;
  int checks = 0;

  mag_shift_add_mult #(.MAG_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mag     (a_mag),
    .a_sign    (a_sign),
    .b_mag     (b_mag),
    .b_sign    (b_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed product by ordinary integer arithmetic.
  function automatic logic [PW-1:0] ref_product(input logic [W-1:0] a, input logic as,
                                                input logic [W-1:0] b, input logic bs);
    longint p;
    logic [63:0] pv;
    p = longint'(a) * longint'(b);
    if (as != bs) p = -p;
    pv = 64'(p);
    return pv[PW-1:0];
  endfunction

  // One full transaction. If hold is set, out_ready stays low for 10 cycles
  // after out_valid while a competing in_valid is presented.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic as,
                        input logic [W-1:0] b, input logic bs, input bit hold);
    logic [PW-1:0] exp_p;
    int  n;
    int  busy_n;
    bit  seen;
    exp_p = ref_product(a, as, b, bs);
    @(negedge clk);
    check({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
    out_ready = !hold;
    in_valid  = 1'b1;
    a_mag = a; a_sign = as; b_mag = b; b_sign = bs;
    @(posedge clk);   // accept edge
    #1;
    in_valid = 1'b0;
    // Operands only need to be stable on the accept edge.
    a_mag = W'($urandom); b_mag = W'($urandom);
    a_sign = 1'($urandom); b_sign = 1'($urandom);
    n = 0; busy_n = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      n++;
    end
    check({tag, ".out_valid_seen"}, 64'(seen), 64'd1);
    check({tag, ".latency"}, 64'(n), 64'(W + 1));
    check({tag, ".product"}, 64'(product), 64'(exp_p));
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        in_valid = 1'b1;
        a_mag = W'($urandom); b_mag = W'($urandom);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".hold_product"}, 64'(product), 64'(exp_p));
        check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);   // handoff edge
    @(negedge clk);
    check({tag, ".in_ready_post"}, 64'(in_ready), 64'd1);
    check({tag, ".out_valid_post"}, 64'(out_valid), 64'd0);
    check({tag, ".product_kept"}, 64'(product), 64'(exp_p));
    check({tag, ".busy_post"}, 64'(busy), 64'd0);
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(W + 2));
  endtask

  initial begin
    bit ov_seen;
    logic [W-1:0] ra, rb;
    logic         rsa, rsb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_mag = '0; a_sign = 1'b0; b_mag = '0; b_sign = 1'b0;

    // Reset state, with in_valid asserted to show it is ignored.
    #1;
    in_valid = 1'b1; a_mag = 16'd9; b_mag = 16'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.product", 64'(product), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Directed cases.
    run_op("p3x5", 16'd3, 1'b0, 16'd5, 1'b0, 1'b0);
    check("p3x5.const", 64'(product), 64'd15);
    run_op("n3x5", 16'd3, 1'b1, 16'd5, 1'b0, 1'b0);
    check("n3x5.const", 64'(product), 64'h1_FFFF_FFF1);
    run_op("nn3x5", 16'd3, 1'b1, 16'd5, 1'b1, 1'b0);
    check("nn3x5.const", 64'(product), 64'd15);
    run_op("max_pos", 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    check("max_pos.const", 64'(product), 64'd4294836225);
    run_op("max_neg", 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    check("max_neg.const", 64'(product), 64'(33'h1_0001_FFFF));
    run_op("zero_a", 16'd0, 1'b1, 16'd1234, 1'b0, 1'b0);
    check("zero_a.const", 64'(product), 64'd0);
    run_op("zero_b", 16'd1, 1'b0, 16'd0, 1'b0, 1'b0);
    check("zero_b.const", 64'(product), 64'd0);

    // Back-pressure: held output, ignored in_valid, then 7 x -9.
    run_op("hold", 16'd321, 1'b0, 16'd77, 1'b1, 1'b1);
    run_op("p7xn9", 16'd7, 1'b0, 16'd9, 1'b1, 1'b0);
    check("p7xn9.const", 64'(product), 64'(33'h1_FFFF_FFC1));

    // Reset five cycles into RUN.
    @(negedge clk);
    in_valid = 1'b1; a_mag = 16'd100; a_sign = 1'b0; b_mag = 16'd200; b_sign = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midrst.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.async_busy", 64'(busy), 64'd0);
    check("midrst.async_in_ready", 64'(in_ready), 64'd1);
    check("midrst.async_out_valid", 64'(out_valid), 64'd0);
    check("midrst.async_product", 64'(product), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid || busy) ov_seen = 1;
    end
    check("midrst.no_output", 64'(ov_seen), 64'd0);
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    run_op("p2x2", 16'd2, 1'b0, 16'd2, 1'b0, 1'b0);
    check("p2x2.const", 64'(product), 64'd4);

    // Random operands against the reference model.
    for (int i = 0; i < 20; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rsa = 1'($urandom);
      rsb = 1'($urandom);
      if (i == 0) ra = '0;
      if (i == 1) rb = 16'hFFFF;
      run_op($sformatf("rand%0d", i), ra, rsa, rb, rsb, (i % 7) == 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mag_shift_add_mult.md
Name: mag_shift_add_mult

Overview:
- Sequential sign-magnitude multiplier for the FIR datapath; sits directly downstream of the signed-to-unsigned magnitude stage.
- Takes two unsigned magnitudes plus their sign bits and computes the unsigned product by shift-and-add, one bit per cycle.
- Reapplies the XOR of the signs as a two's-complement signed product.
- Valid/ready handshake on both sides so it can be time-multiplexed across taps.

Parameters:
- MAG_WIDTH, 16, magnitude width in bits (signed sample width minus 1).
- PROD_WIDTH, 2*MAG_WIDTH+1, signed product width (derived localparam, not overridable).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a_mag  input  MAG_WIDTH  unsigned magnitude of operand A.
- a_sign  input  1  sign of A (1 = negative).
- b_mag  input  MAG_WIDTH  unsigned magnitude of operand B.
- b_sign  input  1  sign of B.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  PROD_WIDTH  signed two's-complement product.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: clock is one domain; reset is asynchronous and active-low.
  - rst_n low forces state=IDLE, out_valid=0, product=0, busy=0, and clears the accumulator, shift registers and iteration counter.
  - in_ready = (state==IDLE), so it is 1 during and after reset.
  - Inputs are ignored while rst_n is low.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - Accept happens on an edge with in_valid && in_ready.
  - On accept: multiplicand register = a_mag zero-extended to 2*MAG_WIDTH; multiplier shift register = b_mag; accumulator = 0; neg = a_sign ^ b_sign; counter = 0.
  - Go to RUN.
- RUN, one iteration per cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand.
  - Multiplicand shifts left by 1; multiplier shifts right by 1; counter increments.
  - After exactly MAG_WIDTH iterations go to FIX. There is no early termination, so latency is data-independent.
- FIX (1 cycle):
  - product = neg ? -{1'b0,acc} : {1'b0,acc}, computed in PROD_WIDTH bits.
  - A zero magnitude yields product 0 regardless of sign.
  - out_valid set to 1; go to DONE.
- DONE:
  - product and out_valid are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. product keeps its last value.
  - in_ready rises the cycle after the handoff; there is no same-cycle accept on output handoff.
- Latency: accept edge t0 → out_valid high after edge t0+MAG_WIDTH+1. Throughput is at most one product per MAG_WIDTH+3 cycles.
- Arithmetic:
  - The accumulator is 2*MAG_WIDTH bits and cannot overflow; the maximum is (2^MAG_WIDTH-1)^2.
  - product range is ±(2^MAG_WIDTH-1)^2, which fits PROD_WIDTH.
- in_valid while not in IDLE: ignored. Operands are not captured and in_ready stays 0.
- Operand inputs need only be stable on the accept edge.
- Reset mid-RUN/FIX/DONE: immediately returns to the reset values above; any in-flight result is discarded and no out_valid pulse is produced.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset release, then a_mag=3, a_sign=0, b_mag=5, b_sign=0, in_valid for 1 cycle → out_valid after 17 edges; product=15; busy high for 18 cycles.
- a_mag=3, a_sign=1, b_mag=5, b_sign=0 → product=-15 (33'h1FFFFFFF1). Repeat with both signs 1 → +15.
- a_mag=65535, b_mag=65535, both signs 1 → product=4294836225. Same operands with a_sign=1 only → -4294836225.
- a_mag=0, a_sign=1, b_mag=1234, b_sign=0 → product=0, not negative zero. a_mag=1, b_mag=0 → 0.
- Hold out_ready=0 for 10 cycles after out_valid → product/out_valid stable, in_ready=0, a new in_valid is ignored. Assert out_ready → in_ready=1 on the following cycle; next operands 7×-9 → -63.
- Pull rst_n low 5 cycles into RUN (operands 100×200) → out_valid stays 0, state IDLE, in_ready=1 after release. A fresh 2×2 → product=4 with normal latency.
